// File: rtl/duty_cycle_clock_ctrl.sv
// Programmable duty-cycle clock generator with a valid/ready config port and glitch-free,
// period-boundary updates. Optional burst support is built when BURST_MODE_EN is defined.
module duty_cycle_clock_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
`ifdef BURST_MODE_EN
    input  logic [7:0]       cfg_burst,
`endif
    output logic             cfg_err,
    input  logic             enable,
    output logic             clk_out,
    output logic             period_done,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             cfg_err_q, cfg_err_d;
    logic             pending_q, pending_d;
    logic             active_valid_q, active_valid_d;
    logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
    logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
    logic [CNT_W-1:0] active_period_q, active_period_d;
    logic [CNT_W-1:0] active_high_q, active_high_d;

    logic             accept;
    logic             legal;
    logic             counting;
    logic             at_last;
    logic             boundary;
    logic             transfer;
    logic             start_fire;
    logic             start_ok;
    logic             burst_stop;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = cfg_valid & ~pending_q;
    assign legal    = (cfg_period >= CNT_W'(2)) && (cfg_high >= CNT_W'(1)) &&
                      (cfg_high <= cfg_period - CNT_W'(1));
    assign counting = (state_q != StIdle);
    assign at_last  = (cnt_q == active_period_q - CNT_W'(1));
    assign boundary = counting & at_last;
    assign cnt_inc  = at_last ? '0 : cnt_q + CNT_W'(1);
    // Shadow is promoted immediately while idle, otherwise only at the wrap edge.
    assign transfer   = pending_q & (~counting | at_last);
    assign start_fire = (state_q == StIdle) & enable & active_valid_q & start_ok;

`ifdef BURST_MODE_EN
    logic [7:0] shadow_burst_q;
    logic [7:0] active_burst_q;
    logic [7:0] burst_cnt_q;
    logic       burst_lock_q;

    assign burst_stop = boundary && (active_burst_q != 8'd0) &&
                        ({1'b0, burst_cnt_q} + 9'd1 >= {1'b0, active_burst_q});
    assign start_ok   = ~burst_lock_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_burst_q <= '0;
            active_burst_q <= '0;
            burst_cnt_q    <= '0;
            burst_lock_q   <= 1'b0;
        end else begin
            if (accept && legal) shadow_burst_q <= cfg_burst;
            if (transfer)        active_burst_q <= shadow_burst_q;
            if (start_fire) begin
                burst_cnt_q <= '0;
            end else if (boundary && burst_cnt_q != 8'hFF) begin
                burst_cnt_q <= burst_cnt_q + 8'd1;
            end
            // A finished burst holds off restart until enable is seen low.
            if (burst_stop) begin
                burst_lock_q <= 1'b1;
            end else if (!enable) begin
                burst_lock_q <= 1'b0;
            end
        end
    end
`else
    assign burst_stop = 1'b0;
    assign start_ok   = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        clk_out_d       = clk_out_q;
        cfg_err_d       = accept & ~legal;
        pending_d       = pending_q;
        active_valid_d  = active_valid_q;
        shadow_period_d = shadow_period_q;
        shadow_high_d   = shadow_high_q;
        active_period_d = active_period_q;
        active_high_d   = active_high_q;

        if (transfer) begin
            active_period_d = shadow_period_q;
            active_high_d   = shadow_high_q;
            pending_d       = 1'b0;
            active_valid_d  = 1'b1;
        end
        if (accept && legal) begin
            shadow_period_d = cfg_period;
            shadow_high_d   = cfg_high;
            pending_d       = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_fire) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                end
            end
            StRun, StDrain: begin
                if ((at_last && !enable) || burst_stop) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                end else begin
                    state_d   = enable ? StRun : StDrain;
                    cnt_d     = cnt_inc;
                    // At the wrap cnt_inc is 0 and any legal high-time is >= 1.
                    clk_out_d = (cnt_inc < active_high_q);
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            clk_out_q       <= 1'b0;
            cfg_err_q       <= 1'b0;
            pending_q       <= 1'b0;
            active_valid_q  <= 1'b0;
            shadow_period_q <= '0;
            shadow_high_q   <= '0;
            active_period_q <= '0;
            active_high_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            clk_out_q       <= clk_out_d;
            cfg_err_q       <= cfg_err_d;
            pending_q       <= pending_d;
            active_valid_q  <= active_valid_d;
            shadow_period_q <= shadow_period_d;
            shadow_high_q   <= shadow_high_d;
            active_period_q <= active_period_d;
            active_high_q   <= active_high_d;
        end
    end

    assign cfg_ready   = ~pending_q;
    assign cfg_err     = cfg_err_q;
    assign clk_out     = clk_out_q;
    assign period_done = boundary;
    assign busy        = counting;

endmodule

// File: tb/tb_duty_cycle_clock_ctrl.sv
// Randomised and directed bench for duty_cycle_clock_ctrl against a period/position model.
module tb_duty_cycle_clock_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             cfg_err;
    logic             enable = 1'b0;
    logic             clk_out;
    logic             period_done;
    logic             busy;
`ifdef BURST_MODE_EN
    logic [7:0]       cfg_burst = 8'd0;
`endif

    duty_cycle_clock_ctrl #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
`ifdef BURST_MODE_EN
        .cfg_burst   (cfg_burst),
`endif
        .cfg_err     (cfg_err),
        .enable      (enable),
        .clk_out     (clk_out),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: is a waveform running, where are we in the period, what is loaded/waiting.
    bit m_busy, m_have, m_pend, m_err;
    int m_pos, m_per, m_hi, m_sh_per, m_sh_hi;

    task automatic model_reset();
        m_busy = 0; m_have = 0; m_pend = 0; m_err = 0;
        m_pos = 0; m_per = 0; m_hi = 0; m_sh_per = 0; m_sh_hi = 0;
    endtask

    task automatic model_update();
        int  p, h;
        bit  bnd, acc, legal, xfer, start;
        p     = int'(cfg_period);
        h     = int'(cfg_high);
        bnd   = m_busy && (m_pos == m_per - 1);
        acc   = cfg_valid && !m_pend;
        legal = (p >= 2) && (h >= 1) && (h <= p - 1);
        xfer  = m_pend && (!m_busy || bnd);
        start = !m_busy && enable && m_have;
        m_err = acc && !legal;
        if (m_busy) begin
            if (bnd && !enable) begin
                m_busy = 0;
                m_pos  = 0;
            end else begin
                m_pos = bnd ? 0 : m_pos + 1;
            end
        end else if (start) begin
            m_busy = 1;
            m_pos  = 0;
        end
        if (xfer) begin
            m_per = m_sh_per; m_hi = m_sh_hi; m_pend = 0; m_have = 1;
        end
        if (acc && legal) begin
            m_sh_per = p; m_sh_hi = h; m_pend = 1;
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        check1("cfg_ready", cfg_ready, !m_pend);
        check1("cfg_err", cfg_err, m_err);
        check1("busy", busy, m_busy);
        check1("clk_out", clk_out, m_busy && (m_pos < m_hi));
        check1("period_done", period_done, m_busy && (m_pos == m_per - 1));
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clock);
        if (reset) model_update();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic wait_pos(input string name, input int per, input int pos);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_busy && m_per == per && m_pos == pos) found = 1;
            else tick();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out waiting for pos %0d of period %0d", name, pos, per);
        end
    endtask

    task automatic wait_free(input string name);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!m_pend) found = 1;
            else tick();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out waiting for cfg_ready", name);
        end
    endtask

    task automatic send_cfg(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        tick();
        cfg_valid  = 1'b0;
    endtask

    logic [19:0] clk_vec, pd_vec;

    initial begin
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs();
        check1("reset_busy", busy, 1'b0);
        check1("reset_ready", cfg_ready, 1'b1);
        reset = 1'b1;
        tick();

        // 10/6 start-up latency and waveform
        enable = 1'b1;
        send_cfg(10, 6);
        check1("start_pending", cfg_ready, 1'b0);
        tick();
        check1("start_not_yet", busy, 1'b0);
        tick();
        check1("start_busy", busy, 1'b1);
        clk_vec = '0;
        pd_vec  = '0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            clk_vec = {clk_vec[18:0], clk_out};
            pd_vec  = {pd_vec[18:0], period_done};
        end
        check_vec("wave_10_6", clk_vec, 20'b11111100001111110000);
        check_vec("done_10_6", pd_vec, 20'b00000000010000000001);

        // Mid-period reconfiguration, then a queued 3/1 behind it
        wait_pos("reconf", 10, 3);
        send_cfg(4, 3);
        check1("reconf_stall", cfg_ready, 1'b0);
        cfg_valid  = 1'b1;
        cfg_period = 8'd3;
        cfg_high   = 8'd1;
        repeat (12) tick();
        cfg_valid = 1'b0;
        repeat (10) tick();

        // Illegal configurations
        wait_free("illegal_a");
        send_cfg(5, 5);
        check1("err_5_5", cfg_err, 1'b1);
        tick();
        check1("err_5_5_clear", cfg_err, 1'b0);
        send_cfg(1, 0);
        check1("err_1_0", cfg_err, 1'b1);
        check1("err_ready", cfg_ready, 1'b1);
        tick();
        check1("err_1_0_clear", cfg_err, 1'b0);

        // Drain to idle, then drain with a re-enable
        send_cfg(8, 4);
        wait_pos("drain_a", 8, 2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("drain_busy", busy, 1'b1);
        end
        tick();
        check1("drain_idle", busy, 1'b0);
        check1("drain_clk", clk_out, 1'b0);
        enable = 1'b1;
        wait_pos("drain_b", 8, 2);
        enable = 1'b0;
        wait_pos("drain_c", 8, 5);
        enable = 1'b1;
        repeat (4) tick();
        check1("reenable_busy", busy, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_valid  = ($urandom_range(0, 9) < 2);
            cfg_period = CNT_W'($urandom_range(0, 12));
            cfg_high   = CNT_W'($urandom_range(0, 13));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            tick();
        end
        cfg_valid = 1'b0;

        // Asynchronous reset in the high phase
        enable = 1'b1;
        wait_free("rst_cfg");
        send_cfg(6, 3);
        wait_pos("rst_high", 6, 0);
        #2 reset = 1'b0;
        #1;
        check1("rst_clk", clk_out, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready", cfg_ready, 1'b1);
        model_reset();
        tick();
        reset = 1'b1;
        repeat (6) tick();
        check1("rst_no_cfg", busy, 1'b0);
        send_cfg(5, 2);
        tick();
        tick();
        check1("rst_restart", busy, 1'b1);
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
